hamming_arbiter: RTL

- Shares the single pipelined hamming_distance unit between two requesters: port 0 is the USB vendor-request handler and port 1 is the find_best_iso search engine.
- Accepts one operand pair per cycle, chosen round-robin, and drives the hamming unit inputs.
- Tags each operation in flight and returns each distance to the requester that issued it.
- Sits in the top level between both requesters and the hamming_distance instance; all logic is on clk_50.

---
 rtl/hamming_arbiter_if.sv | 43 ++++
 rtl/hamming_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/hamming_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared
// hamming_distance unit.
//   pause            : stop issuing new grants
//   req*/a*/b*       : operand pair handshake, requester 0 and 1
//   gnt*             : combinational grant back to each requester
//   res_valid*       : one-cycle result strobe per requester
//   res_dist         : shared result bus
//   ham_a/ham_b      : registered operands to the hamming unit
//   ham_dist         : distance returned by the hamming unit
//   busy             : any operation in flight
interface hamming_arbiter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIST_W = 4
);
  logic              pause;
  logic              req0;
  logic [WIDTH-1:0]  a0;
  logic [WIDTH-1:0]  b0;
  logic              gnt0;
  logic              res_valid0;
  logic              req1;
  logic [WIDTH-1:0]  a1;
  logic [WIDTH-1:0]  b1;
  logic              gnt1;
  logic              res_valid1;
  logic [DIST_W-1:0] res_dist;
  logic [WIDTH-1:0]  ham_a;
  logic [WIDTH-1:0]  ham_b;
  logic [DIST_W-1:0] ham_dist;
  logic              busy;

  // Arbiter side
  modport slave (
    input  pause, req0, a0, b0, req1, a1, b1, ham_dist,
    output gnt0, res_valid0, gnt1, res_valid1, res_dist, ham_a, ham_b, busy
  );

  // Requester / hamming unit side
  modport master (
    output pause, req0, a0, b0, req1, a1, b1, ham_dist,
    input  gnt0, res_valid0, gnt1, res_valid1, res_dist, ham_a, ham_b, busy
  );
endinterface

// File: rtl/hamming_arbiter.sv
// Round-robin arbiter sharing one pipelined hamming_distance unit between
// two requesters. Each accepted operand pair is tagged with its requester
// id; the tag travels alongside the hamming pipeline and steers the result
// back to the issuing requester.
//   clock   : system clock
//   reset_n : synchronous active-low reset
//   bus     : hamming_arbiter_if slave port (requesters + hamming unit)
module hamming_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIST_W  = 4,
  parameter int unsigned HAM_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  hamming_arbiter_if.slave bus
);

  // One stage for the operand register plus HAM_LAT stages in the unit.
  localparam int unsigned DEPTH = HAM_LAT + 1;

  logic [DEPTH-1:0]  r_tag_vld;
  logic [DEPTH-1:0]  r_tag_id;
  logic              r_last_grant;
  logic [WIDTH-1:0]  r_ham_a;
  logic [WIDTH-1:0]  r_ham_b;
  logic [DIST_W-1:0] r_res_dist;
  logic              r_res_valid0;
  logic              r_res_valid1;

  logic w_gnt0;
  logic w_gnt1;
  logic w_xfer0;
  logic w_xfer1;
  logic w_xfer;

  // Grant: on a tie the requester that did not win last time goes first.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset_n && !bus.pause) begin
      if (bus.req0 && bus.req1) begin
        w_gnt0 = r_last_grant;
        w_gnt1 = !r_last_grant;
      end else begin
        w_gnt0 = bus.req0;
        w_gnt1 = bus.req1;
      end
    end
  end

  assign w_xfer0 = bus.req0 && w_gnt0;
  assign w_xfer1 = bus.req1 && w_gnt1;
  assign w_xfer  = w_xfer0 || w_xfer1;

  // Operand register, tag pipeline and result stage.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ham_a      <= '0;
      r_ham_b      <= '0;
      r_last_grant <= 1'b1;
      r_tag_vld    <= '0;
      r_tag_id     <= '0;
      r_res_dist   <= '0;
      r_res_valid0 <= 1'b0;
      r_res_valid1 <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_ham_a      <= w_xfer0 ? bus.a0 : bus.a1;
        r_ham_b      <= w_xfer0 ? bus.b0 : bus.b1;
        r_last_grant <= w_xfer1;
      end
      r_tag_vld[0] <= w_xfer;
      r_tag_id[0]  <= w_xfer1;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
      // The tag leaving the last stage lines up with ham_dist for its pair.
      r_res_valid0 <= r_tag_vld[DEPTH-1] && !r_tag_id[DEPTH-1];
      r_res_valid1 <= r_tag_vld[DEPTH-1] &&  r_tag_id[DEPTH-1];
      if (r_tag_vld[DEPTH-1]) begin
        r_res_dist <= bus.ham_dist;
      end
    end
  end

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.ham_a      = r_ham_a;
  assign bus.ham_b      = r_ham_b;
  assign bus.res_dist   = r_res_dist;
  assign bus.res_valid0 = r_res_valid0;
  assign bus.res_valid1 = r_res_valid1;
  assign bus.busy       = (|r_tag_vld) || r_res_valid0 || r_res_valid1;

endmodule
